tick_token_source: RTL and testbench
====================================

// Module: tick_token_source
// PURPOSE
//  Consumes the divided slow clock (clk_out of clock_divider) as a data signal in the clk_in domain.
//  - Detects each rising edge of the slow clock.
//  - Turns each edge into a one-cycle tick strobe and a sequence-numbered token on a valid/ready channel.
//  - Sits between the clock divider and the KPN process FIFOs; it is the timing source of the network.
//  - Ticks that cannot be delivered are counted as drops, not queued.
// PARAMETERS
//  DATA_W       8   width of token sequence number (out_data), wraps modulo 2^DATA_W
//  SYNC_STAGES  2   slow_clk synchronizer depth, legal 1..3
//  DROP_W       8   width of dropped-tick counter, saturating
// PORTS
//  clk_in         in   1       system clock (50 MHz), all logic on posedge
//  rst_n          in   1       asynchronous active-low reset
//  slow_clk       in   1       divided clock from clock_divider, sampled as data
//  enable         in   1       1 = ticks generate tokens; 0 = ticks ignored
//  out_ready      in   1       downstream accepts token this cycle
//  out_valid      out  1       token held in output register
//  out_data       out  DATA_W  sequence number of held token
//  tick           out  1       one-cycle strobe per qualified rising edge
//  dropped_count  out  DROP_W  ticks lost because output was full (saturates at all-ones)
//  overflow       out  1       sticky, set on first drop
//  clear_drops    in   1       sync clear of dropped_count and overflow
// BEHAVIOUR
//  Reset:
//  - rst_n low clears every flop asynchronously: sync chain, edge history, arm counter, seq, output register.
//  - Outputs during reset: out_valid=0, out_data=0, tick=0, dropped_count=0, overflow=0.
//  - A token held when reset asserts is discarded.
//  Arming:
//  - Edge detector is unarmed for SYNC_STAGES+1 clocks after rst_n release.
//  - While unarmed, history tracks the sync output and tick is forced 0.
//  - A slow_clk already high at reset release therefore never produces a tick.
//  Edge detection:
//  - edge = sync_out & ~hist; tick = edge & armed & enable (registered-term combinational AND).
//  - A slow_clk rise captured at posedge k gives tick high in the cycle after posedge k+SYNC_STAGES-1.
//  - Exactly one tick per slow_clk rising edge.
//  - enable=0 suppresses tick but history keeps tracking, so re-enable mid-high gives no tick.
//  Sequence counter seq:
//  - Starts at 0 and increments on every tick, including dropped ticks.
//  - Gaps in out_data therefore reveal drops.
//  - Wraps from 2^DATA_W-1 to 0 with no flag.
//  Output register, 2-state FSM:
//  - EMPTY (out_valid=0):
//    - tick -> load out_data=seq, go to FULL at next edge.
//    - Token latency: out_valid rises 1 clock after tick.
//  - FULL (out_valid=1):
//    - out_data is stable while out_valid=1 and out_ready=0.
//    - out_ready & ~tick -> EMPTY.
//    - out_ready & tick -> stay FULL, load new seq; no bubble, no drop.
//    - ~out_ready & tick -> drop: seq still increments, held token unchanged.
//      dropped_count += 1 unless all-ones; overflow <= 1.
//  clear_drops:
//  - Sets dropped_count=0 and overflow=0 next clock.
//  - If a drop occurs the same cycle: dropped_count=1, overflow=1.
//  - Does not affect seq or the token.
//  Other rules:
//  - enable=0 while FULL: token remains until accepted; no new tokens.
//  - All arithmetic is unsigned.
// TESTING
//  1 slow_clk period 8 clk, out_ready=1, enable=1 -> tokens 0,1,2,3 at 8-clk spacing; out_valid 1 clk wide each.
//  2 rst_n release with slow_clk=1 -> no tick and no token until the next rising edge; that token has data 0.
//  3 out_ready=0 for 3 ticks -> token 0 held; dropped_count=2, overflow=1; on ready, next token data=3.
//  4 DATA_W=2, 5 ticks with ready=1 -> out_data 0,1,2,3,0.
//  5 DROP_W=2, 6 drops -> dropped_count sticks at 3; clear_drops together with a drop -> dropped_count=1.
//  6 Assert rst_n low mid-FULL -> out_valid=0 immediately (async); enable=0 during an edge -> no tick, seq unchanged.

Source files
------------

// File: rtl/tick_token_source.sv
// Turns rising edges of the divided slow clock into one-cycle tick strobes and
// sequence-numbered tokens on a single-entry valid/ready output; undeliverable ticks are counted.
module tick_token_source #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_W      = 8
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              slow_clk,
  input  logic              enable,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              tick,
  output logic [DROP_W-1:0] dropped_count,
  output logic              overflow,
  input  logic              clear_drops
);

  localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                hist_q;
  logic [ARM_W-1:0]    arm_q, arm_d;
  logic [DATA_W-1:0]   seq_q, seq_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DROP_W-1:0]   drops_q, drops_d;
  logic                ovf_q, ovf_d;

  logic sync_out, armed, edge_det, load, drop;

  assign sync_d   = SYNC_STAGES'({sync_q, slow_clk});
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign armed    = (arm_q == ARM_DONE);
  assign arm_d    = armed ? arm_q : arm_q + 1'b1;
  // History follows the synchronizer even while unarmed or disabled, so a level
  // that was already high never looks like a fresh edge later.
  assign edge_det = sync_out & ~hist_q;
  assign tick     = edge_det & armed & enable;

  // State register.
  // NOTE: every flop, including the held token, is cleared by the async reset so
  // a token in flight at reset is discarded rather than replayed.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      EMPTY: if (tick)              state_d = FULL;
      FULL:  if (out_ready && !tick) state_d = EMPTY;
      default:                      state_d = EMPTY;
    endcase
  end

  // Output / datapath control decoded from state.
  always_comb begin
    out_valid = (state_q == FULL);
    load      = tick && ((state_q == EMPTY) || out_ready);
    drop      = tick && (state_q == FULL) && !out_ready;
  end

  always_comb begin
    seq_d   = tick ? seq_q + 1'b1 : seq_q;
    data_d  = load ? seq_q : data_q;
    drops_d = drops_q;
    ovf_d   = ovf_q;
    if (clear_drops) begin
      drops_d = DROP_W'(drop);
      ovf_d   = drop;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drops_q != '1) drops_d = drops_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      arm_q   <= '0;
      seq_q   <= '0;
      data_q  <= '0;
      drops_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= sync_out;
      arm_q   <= arm_d;
      seq_q   <= seq_d;
      data_q  <= data_d;
      drops_q <= drops_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data      = data_q;
  assign dropped_count = drops_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_tick_token_source.sv
// Self-checking bench: two configurations driven in parallel, compared every cycle
// against an index-based model of the slow_clk sample history plus a token/drop model.
module tb_tick_token_source;

  logic clk = 1'b0;
  logic rst_n, slow_clk, enable, out_ready, clear_drops;

  logic       va, ta, ova;
  logic [7:0] da, dca;
  logic       vb, tb, ovb;
  logic [1:0] db, dcb;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;

  tick_token_source dut_a (
    .clk_in(clk), .rst_n(rst_n), .slow_clk(slow_clk), .enable(enable),
    .out_ready(out_ready), .out_valid(va), .out_data(da), .tick(ta),
    .dropped_count(dca), .overflow(ova), .clear_drops(clear_drops));

  tick_token_source #(.DATA_W(2), .SYNC_STAGES(3), .DROP_W(2)) dut_b (
    .clk_in(clk), .rst_n(rst_n), .slow_clk(slow_clk), .enable(enable),
    .out_ready(out_ready), .out_valid(vb), .out_data(db), .tick(tb),
    .dropped_count(dcb), .overflow(ovb), .clear_drops(clear_drops));

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // samp[j-1] is slow_clk as seen at the j-th rising clk edge since reset release.
  bit samp[$];
  int  seq_m[2], data_m[2], drops_m[2];
  bit  valid_m[2], ovf_m[2];

  function automatic int sync_depth(input int i);
    return (i == 0) ? 2 : 3;
  endfunction
  function automatic int data_mod(input int i);
    return (i == 0) ? 256 : 4;
  endfunction
  function automatic int drop_max(input int i);
    return (i == 0) ? 255 : 3;
  endfunction

  function automatic bit s_at(input int j);
    if (j < 1 || j > samp.size()) return 1'b0;
    return samp[j-1];
  endfunction

  // Tick in the cycle after edge n: armed after S+1 edges, synchronized sample
  // s[n-S+1] is high while the previous one s[n-S] was low.
  function automatic bit tick_exp(input int i);
    int s = sync_depth(i);
    int n = samp.size();
    return rst_n && enable && (n >= s + 1) && s_at(n - s + 1) && !s_at(n - s);
  endfunction

  always @(negedge rst_n) begin
    samp.delete();
    for (int i = 0; i < 2; i++) begin
      seq_m[i] = 0; data_m[i] = 0; drops_m[i] = 0; valid_m[i] = 0; ovf_m[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        bit t, dr;
        t  = tick_exp(i);
        dr = valid_m[i] && !out_ready && t;
        if (t) begin
          if (!valid_m[i] || out_ready) begin
            data_m[i]  = seq_m[i];
            valid_m[i] = 1'b1;
          end
          seq_m[i] = (seq_m[i] + 1) % data_mod(i);
        end else if (valid_m[i] && out_ready) begin
          valid_m[i] = 1'b0;
        end
        if (clear_drops) begin
          drops_m[i] = dr ? 1 : 0;
          ovf_m[i]   = dr;
        end else if (dr) begin
          ovf_m[i] = 1'b1;
          if (drops_m[i] < drop_max(i)) drops_m[i]++;
        end
      end
      samp.push_back(slow_clk);
    end
  end

  always @(negedge clk) begin
    check("tick_a",  int'(ta),  int'(tick_exp(0)));
    check("valid_a", int'(va),  int'(valid_m[0]));
    check("data_a",  int'(da),  data_m[0]);
    check("drops_a", int'(dca), drops_m[0]);
    check("ovf_a",   int'(ova), int'(ovf_m[0]));
    check("tick_b",  int'(tb),  int'(tick_exp(1)));
    check("valid_b", int'(vb),  int'(valid_m[1]));
    check("data_b",  int'(db),  data_m[1]);
    check("drops_b", int'(dcb), drops_m[1]);
    check("ovf_b",   int'(ovb), int'(ovf_m[1]));
  end

  // ---------------- capture of accepted tokens ----------------
  int acc_a[$], acc_b[$], stamp_a[$];
  int vcnt_a = 0, tcnt_a = 0, tcnt_b = 0;

  always @(posedge clk) begin
    cyc_cnt++;
    if (rst_n) begin
      if (va && out_ready) begin acc_a.push_back(int'(da)); stamp_a.push_back(cyc_cnt); end
      if (vb && out_ready) acc_b.push_back(int'(db));
      if (va) vcnt_a++;
      if (ta) tcnt_a++;
      if (tb) tcnt_b++;
    end
  end

  function automatic int qa(input int idx);
    return (idx < acc_a.size()) ? acc_a[idx] : -1;
  endfunction
  function automatic int qb(input int idx);
    return (idx < acc_b.size()) ? acc_b[idx] : -1;
  endfunction
  function automatic int qs(input int idx);
    return (idx < stamp_a.size()) ? stamp_a[idx] : -1;
  endfunction

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit level, input int idle);
    rst_n = 1'b0; slow_clk = level; clear_drops = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(idle);
  endtask

  task automatic slow_period(input int n);
    repeat (n) begin
      slow_clk = 1'b1; cyc(4);
      slow_clk = 1'b0; cyc(4);
    end
  endtask

  int ba, bb, bs, bv, bt;

  initial begin
    rst_n = 1'b0; slow_clk = 1'b0; enable = 1'b1; out_ready = 1'b1; clear_drops = 1'b0;
    cyc(1);

    // 1 + 4: five ticks, ready=1: 8-bit counts 0..4 at 8-clk spacing, 2-bit wraps to 0.
    do_reset(1'b0, 6);
    ba = acc_a.size(); bb = acc_b.size(); bs = stamp_a.size(); bv = vcnt_a;
    slow_period(5); cyc(8);
    check("t1_count_a", acc_a.size() - ba, 5);
    for (int i = 0; i < 5; i++) check("t1_data_a", qa(ba + i), i);
    for (int i = 1; i < 5; i++) check("t1_spacing", qs(bs + i) - qs(bs + i - 1), 8);
    check("t1_valid_width", vcnt_a - bv, 5);
    check("t4_b0", qb(bb + 0), 0);
    check("t4_b1", qb(bb + 1), 1);
    check("t4_b2", qb(bb + 2), 2);
    check("t4_b3", qb(bb + 3), 3);
    check("t4_b4", qb(bb + 4), 0);

    // 2: release with slow_clk already high gives nothing until the next rise.
    ba = acc_a.size(); bb = acc_b.size(); bt = tcnt_a;
    do_reset(1'b1, 10);
    check("t2_no_tick", tcnt_a - bt, 0);
    check("t2_no_token", acc_a.size() - ba, 0);
    slow_clk = 1'b0; cyc(4);
    slow_period(1); cyc(8);
    check("t2_first_a", qa(ba), 0);
    check("t2_first_b", qb(bb), 0);

    // 3: three ticks with ready low -> token 0 held, two drops; then next token is 3.
    out_ready = 1'b0;
    do_reset(1'b0, 6);
    slow_period(3); cyc(4);
    check("t3_valid", int'(va), 1);
    check("t3_data", int'(da), 0);
    check("t3_drops_a", int'(dca), 2);
    check("t3_ovf_a", int'(ova), 1);
    check("t3_drops_b", int'(dcb), 2);
    ba = acc_a.size();
    out_ready = 1'b1; cyc(2);
    slow_period(1); cyc(8);
    check("t3_held", qa(ba), 0);
    check("t3_next", qa(ba + 1), 3);

    // 5: saturation of the 2-bit drop counter, then clear coincident with a drop.
    out_ready = 1'b0;
    do_reset(1'b0, 6);
    slow_period(7);
    check("t5_sat_b", int'(dcb), 3);
    check("t5_drops_a", int'(dca), 6);
    slow_clk = 1'b1;
    cyc(3);
    clear_drops = 1'b1; cyc(1);
    clear_drops = 1'b0;
    check("t5_clear_drop_b", int'(dcb), 1);
    check("t5_clear_ovf_b", int'(ovb), 1);
    check("t5_clear_a", int'(dca), 0);
    check("t5_clear_ovf_a", int'(ova), 0);
    slow_clk = 1'b0; cyc(4);

    // 6: async reset while FULL, then edges while disabled leave seq untouched.
    do_reset(1'b0, 6);
    slow_period(1); cyc(2);
    check("t6_full", int'(va), 1);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    check("t6_async_valid_a", int'(va), 0);
    check("t6_async_valid_b", int'(vb), 0);
    check("t6_async_data", int'(da), 0);
    cyc(1);
    rst_n = 1'b1; out_ready = 1'b1; enable = 1'b0;
    cyc(6);
    ba = acc_a.size(); bt = tcnt_a;
    slow_period(2);
    check("t6_dis_tick", tcnt_a - bt, 0);
    enable = 1'b1;
    slow_period(1); cyc(8);
    check("t6_en_tick", tcnt_a - bt, 1);
    check("t6_seq_kept", qa(ba), 0);

    // Randomized traffic with one mid-run reset; the per-cycle compare does the checking.
    do_reset(1'b0, 0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) slow_clk = ~slow_clk;
      out_ready   = ($urandom_range(0, 2) != 0);
      enable      = ($urandom_range(0, 9) != 0);
      clear_drops = ($urandom_range(0, 49) == 0);
      if (k == 1500) begin
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
      end
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
